// File: rtl/sprite_pkg.sv
// Shared types, widths and attribute-word field positions for the sprite attribute fetch path.
package sprite_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RAM_AW = 8;
  localparam int unsigned LINE_W = 10;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned ROW_W  = 6;

  // W0 (even word) field positions
  localparam int unsigned W0_ADDR_LSB = 0;
  localparam int unsigned W0_MODE_BIT = 15;
  localparam int unsigned W0_X_LSB    = 16;

  // W1 (odd word) field positions
  localparam int unsigned W1_Y_LSB      = 0;
  localparam int unsigned W1_HFLIP_BIT  = 16;
  localparam int unsigned W1_VFLIP_BIT  = 17;
  localparam int unsigned W1_Z_LSB      = 18;
  localparam int unsigned W1_COLL_LSB   = 20;
  localparam int unsigned W1_PAL_LSB    = 24;
  localparam int unsigned W1_WIDTH_LSB  = 28;
  localparam int unsigned W1_HEIGHT_LSB = 30;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    CHK,
    CAP,
    EMIT,
    FIN
  } fetch_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] addr;
    logic              mode;
    logic [X_W-1:0]    x;
    logic [ROW_W-1:0]  row;
    logic [1:0]        width;
    logic              hflip;
    logic [1:0]        z;
    logic [3:0]        coll;
    logic [3:0]        pal;
  } sprite_rec_t;

  // Sprite height in lines for a 2-bit height code (8 << code).
  function automatic logic [6:0] height_px(input logic [1:0] code);
    return 7'(7'd8 << code);
  endfunction

endpackage

// File: rtl/sprite_line_hit.sv
// Combinational line/sprite intersection: visibility and vflip-corrected row for one sprite.
module sprite_line_hit
  import sprite_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [Y_W-1:0]    y_i,
  input  logic [1:0]        height_i,
  input  logic              vflip_i,
  input  logic [1:0]        z_i,
  output logic              visible_c,
  output logic [ROW_W-1:0]  row_c
);

  logic [LINE_W-1:0] diff;
  logic [LINE_W-1:0] h;

  // 10-bit wrap lets sprites with negative Y (stored as 1024-n) clip at the top.
  always_comb begin
    diff      = line_i - y_i;
    h         = LINE_W'(height_px(height_i));
    visible_c = (z_i != 2'd0) && (diff < h);
    row_c     = vflip_i ? ROW_W'(h - LINE_W'(1) - diff) : ROW_W'(diff);
  end

endmodule

// File: rtl/sprite_attr_fetch.sv
// Per-scanline sprite attribute scanner: emits decoded records of visible sprites on a valid/ready stream.
// Optional SPRITE_FETCH_OVERFLOW_EN adds a sticky overflow_o flag with overflow_clr_i.
module sprite_attr_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 128,
  parameter int unsigned MAX_PER_LINE = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  input  logic               line_start_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [RAM_AW-1:0]  rd_addr_o,
  output logic               rd_en_o,
  input  logic [WORD_W-1:0]  rd_data_i,
  output logic               spr_valid_o,
  input  logic               spr_ready_i,
  output logic [IDX_W-1:0]   spr_idx_o,
  output logic [ADDR_W-1:0]  spr_addr_o,
  output logic               spr_mode_o,
  output logic [X_W-1:0]     spr_x_o,
  output logic [ROW_W-1:0]   spr_row_o,
  output logic [1:0]         spr_width_o,
  output logic               spr_hflip_o,
  output logic [1:0]         spr_z_o,
  output logic [3:0]         spr_coll_o,
  output logic [3:0]         spr_pal_o,
  output logic               busy_o,
  output logic               done_o
`ifdef SPRITE_FETCH_OVERFLOW_EN
  ,
  input  logic               overflow_clr_i,
  output logic               overflow_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

  fetch_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  emitted_q, emitted_d, emitted_inc;
  logic [LINE_W-1:0] line_q, line_d;
  sprite_rec_t       rec_q, rec_d;
  logic [RAM_AW-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start, last_idx, limit_hit;
  logic              hit_visible;
  logic [ROW_W-1:0]  hit_row;
  logic              unused_bits;
`ifdef SPRITE_FETCH_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  assign start       = line_start_i && enable_i;
  assign emitted_inc = emitted_q + CNT_W'(1);
  assign last_idx    = (idx_q == IDX_W'(NUM_SPRITES - 1));
  assign limit_hit   = (emitted_inc == CNT_W'(MAX_PER_LINE));
  assign unused_bits = ^rd_data_i[14:12];

  sprite_line_hit u_hit (
    .line_i    (line_q),
    .y_i       (rd_data_i[W1_Y_LSB +: Y_W]),
    .height_i  (rd_data_i[W1_HEIGHT_LSB +: 2]),
    .vflip_i   (rd_data_i[W1_VFLIP_BIT]),
    .z_i       (rd_data_i[W1_Z_LSB +: 2]),
    .visible_c (hit_visible),
    .row_c     (hit_row)
  );

  // W0 read must be on the port during CHK, so its visibility-dependent strobe is decoded here.
  assign rd_en_o = (state_q == RD1) || ((state_q == CHK) && hit_visible);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    emitted_d = emitted_q;
    line_d    = line_q;
    rec_d     = rec_q;
    valid_d   = valid_q;
`ifdef SPRITE_FETCH_OVERFLOW_EN
    ovf_d     = overflow_clr_i ? 1'b0 : ovf_q;
`endif
    if (start) begin
      line_d    = line_i;
      idx_d     = '0;
      emitted_d = '0;
      valid_d   = 1'b0;
      state_d   = RD1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RD1:  state_d = CHK;
        CHK: begin
          if (hit_visible) begin
            rec_d.idx   = idx_q;
            rec_d.row   = hit_row;
            rec_d.width = rd_data_i[W1_WIDTH_LSB +: 2];
            rec_d.hflip = rd_data_i[W1_HFLIP_BIT];
            rec_d.z     = rd_data_i[W1_Z_LSB +: 2];
            rec_d.coll  = rd_data_i[W1_COLL_LSB +: 4];
            rec_d.pal   = rd_data_i[W1_PAL_LSB +: 4];
            state_d     = CAP;
          end else if (last_idx) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD1;
          end
        end
        CAP: begin
          rec_d.addr = rd_data_i[W0_ADDR_LSB +: ADDR_W];
          rec_d.mode = rd_data_i[W0_MODE_BIT];
          rec_d.x    = rd_data_i[W0_X_LSB +: X_W];
          valid_d    = 1'b1;
          state_d    = EMIT;
        end
        EMIT: begin
          if (spr_ready_i) begin
            valid_d   = 1'b0;
            emitted_d = emitted_inc;
            if (last_idx || limit_hit) begin
              state_d = FIN;
`ifdef SPRITE_FETCH_OVERFLOW_EN
              if (limit_hit && !last_idx) ovf_d = 1'b1;
`endif
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = RD1;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Odd word on entry to RD1; even word is preloaded for CHK so a hit can read W0 at once.
    rd_addr_d = rd_addr_q;
    if (state_d == RD1) begin
      rd_addr_d = {idx_d, 1'b1};
    end else if (state_d == CHK) begin
      rd_addr_d = {idx_q, 1'b0};
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      emitted_q <= '0;
      line_q    <= '0;
      rec_q     <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPRITE_FETCH_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      emitted_q <= emitted_d;
      line_q    <= line_d;
      rec_q     <= rec_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPRITE_FETCH_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign spr_valid_o = valid_q;
  assign spr_idx_o   = rec_q.idx;
  assign spr_addr_o  = rec_q.addr;
  assign spr_mode_o  = rec_q.mode;
  assign spr_x_o     = rec_q.x;
  assign spr_row_o   = rec_q.row;
  assign spr_width_o = rec_q.width;
  assign spr_hflip_o = rec_q.hflip;
  assign spr_z_o     = rec_q.z;
  assign spr_coll_o  = rec_q.coll;
  assign spr_pal_o   = rec_q.pal;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef SPRITE_FETCH_OVERFLOW_EN
  assign overflow_o  = ovf_q;
`endif

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Bench for sprite_attr_fetch: table-level model of visible sprites per line, per-cycle stream check.
module tb_sprite_attr_fetch;

  typedef logic [48:0] rec_t;

  logic        clk = 1'b0;
  logic        rst_n, enable, line_start, ready, chk_en;
  logic [9:0]  line_val;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        spr_valid, spr_mode, spr_hflip, busy, done;
  logic [6:0]  spr_idx;
  logic [11:0] spr_addr;
  logic [9:0]  spr_x;
  logic [5:0]  spr_row;
  logic [1:0]  spr_width, spr_z;
  logic [3:0]  spr_coll, spr_pal;

  logic        start70;
  logic [7:0]  rd_addr70;
  logic        rd_en70;
  logic [31:0] rd_data70;
  logic        valid70, mode70, hflip70, busy70, done70;
  logic [6:0]  idx70;
  logic [11:0] addr70;
  logic [9:0]  x70;
  logic [5:0]  row70;
  logic [1:0]  width70, z70;
  logic [3:0]  coll70, pal70;
`ifdef SPRITE_FETCH_OVERFLOW_EN
  logic        ovf_clr, ovf, ovf_clr70, ovf70;
`endif

  logic [31:0] mem   [256];
  logic [31:0] mem70 [256];
  rec_t        exp_q[$];
  rec_t        act_rec;
  logic [60:0] all_outs;
  logic        unused_tb;

  int checks = 0, passes = 0, fails = 0;
  int rd_cnt = 0, done_cnt = 0, acc_cnt = 0, acc70 = 0;
  int last_idx_acc = 0, last_row_acc = 0, last_addr_acc = 0, last_x_acc = 0;

  always #5 clk = ~clk;

  assign act_rec  = {spr_idx, spr_addr, spr_mode, spr_x, spr_row, spr_width, spr_hflip, spr_z, spr_coll, spr_pal};
  assign all_outs = {rd_addr, rd_en, spr_valid, act_rec, busy, done};
  assign unused_tb = ^{rd_addr70, rd_en70, mode70, hflip70, busy70, addr70, x70, row70, width70, z70, coll70, pal70};

  sprite_attr_fetch dut (
`ifdef SPRITE_FETCH_OVERFLOW_EN
    .overflow_clr_i(ovf_clr), .overflow_o(ovf),
`endif
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .line_start_i(line_start), .line_i(line_val),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en), .rd_data_i(rd_data),
    .spr_valid_o(spr_valid), .spr_ready_i(ready), .spr_idx_o(spr_idx), .spr_addr_o(spr_addr),
    .spr_mode_o(spr_mode), .spr_x_o(spr_x), .spr_row_o(spr_row), .spr_width_o(spr_width),
    .spr_hflip_o(spr_hflip), .spr_z_o(spr_z), .spr_coll_o(spr_coll), .spr_pal_o(spr_pal),
    .busy_o(busy), .done_o(done)
  );

  sprite_attr_fetch #(.NUM_SPRITES(70), .MAX_PER_LINE(64)) dut70 (
`ifdef SPRITE_FETCH_OVERFLOW_EN
    .overflow_clr_i(ovf_clr70), .overflow_o(ovf70),
`endif
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(1'b1), .line_start_i(start70), .line_i(10'd0),
    .rd_addr_o(rd_addr70), .rd_en_o(rd_en70), .rd_data_i(rd_data70),
    .spr_valid_o(valid70), .spr_ready_i(1'b1), .spr_idx_o(idx70), .spr_addr_o(addr70),
    .spr_mode_o(mode70), .spr_x_o(x70), .spr_row_o(row70), .spr_width_o(width70),
    .spr_hflip_o(hflip70), .spr_z_o(z70), .spr_coll_o(coll70), .spr_pal_o(pal70),
    .busy_o(busy70), .done_o(done70)
  );

  // Synchronous-read RAM models
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (rd_en70) rd_data70 <= mem70[rd_addr70];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_w0(input int addr, input int mode, input int x);
    return 32'(addr & 12'hFFF) | (32'(mode & 1) << 15) | (32'(x & 10'h3FF) << 16);
  endfunction

  function automatic logic [31:0] mk_w1(input int y, input int hf, input int vf, input int z,
                                        input int coll, input int pal, input int wd, input int hc);
    return 32'(y & 10'h3FF) | (32'(hf & 1) << 16) | (32'(vf & 1) << 17) | (32'(z & 3) << 18) |
           (32'(coll & 15) << 20) | (32'(pal & 15) << 24) | (32'(wd & 3) << 28) | (32'(hc & 3) << 30);
  endfunction

  // Expected records for a line: scan the table in order, keep enabled sprites covering the line.
  task automatic build_exp(input int line);
    logic [31:0] w0, w1;
    int y, h, diff, row;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      if (exp_q.size() >= 64) break;
      w0 = mem[2*i];
      w1 = mem[2*i+1];
      y = int'(w1[9:0]);
      h = 8 << w1[31:30];
      diff = (line - y + 1024) % 1024;
      if (w1[19:18] != 2'd0 && diff < h) begin
        row = (w1[17] == 1'b1) ? (h - 1 - diff) : diff;
        exp_q.push_back({7'(i), w0[11:0], w0[15], w0[25:16], 6'(row), w1[29:28], w1[16],
                         w1[19:18], w1[23:20], w1[27:24]});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic load_t2(input int vf);
    clear_mem();
    mem[6]  = mk_w0(12'hABC, 1, 300);
    mem[7]  = mk_w1(100, 1, vf, 2, 5, 9, 2, 1);
    mem[11] = mk_w1(100, 0, 0, 0, 0, 0, 0, 1);
    mem[15] = mk_w1(200, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic start_scan(input int line);
    build_exp(line);
    line_val   = 10'(line);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int pat, output int n);
    n = 0;
    while (!done && n < budget) begin
      ready = (pat == 0) ? 1'b1 : ((n % pat) != 0);
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!spr_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_seen", spr_valid, 1);
  endtask

  // Per-cycle stream check against the model queue
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        chk("drain_at_done", exp_q.size(), 0);
      end
      if (spr_valid) begin
        chk("record_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("record", act_rec, exp_q[0]);
          chk("no_read_in_emit", rd_en, 0);
          if (ready) begin
            acc_cnt++;
            last_idx_acc  = int'(spr_idx);
            last_row_acc  = int'(spr_row);
            last_addr_acc = int'(spr_addr);
            last_x_acc    = int'(spr_x);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid70) begin
      chk("limit_order", idx70, acc70);
      acc70++;
    end
  end

  initial begin
    int n;
    rec_t snap;
    rst_n = 1'b0; enable = 1'b1; line_start = 1'b0; line_val = '0; ready = 1'b1;
    chk_en = 1'b0; start70 = 1'b0;
`ifdef SPRITE_FETCH_OVERFLOW_EN
    ovf_clr = 1'b0; ovf_clr70 = 1'b0;
`endif
    clear_mem();
    for (int i = 0; i < 70; i++) begin
      mem70[2*i]   = mk_w0(i, 0, i);
      mem70[2*i+1] = mk_w1(0, 0, 0, 1, 0, 0, 0, 0);
    end
    for (int i = 140; i < 256; i++) mem70[i] = 32'd0;
    repeat (3) tick();
    chk("reset_outputs", all_outs, 0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Empty table
    rd_cnt = 0; done_cnt = 0; acc_cnt = 0;
    start_scan(5);
    run_until_done(400, 0, n);
    chk("empty_done_cycle", longint'((n + 2 >= 257) && (n + 2 <= 259)), 1);
    chk("empty_rd_strobes", rd_cnt, 128);
    chk("empty_records", acc_cnt, 0);
    chk("empty_idle_after", {busy, done, spr_valid}, 0);

    // Single visible sprite, then vflip
    load_t2(0);
    build_exp(107);
    chk("model_t2_size", exp_q.size(), 1);
    acc_cnt = 0;
    start_scan(107);
    run_until_done(600, 0, n);
    chk("t2_cycles", n, 258);
    chk("t2_count", acc_cnt, 1);
    chk("t2_idx", last_idx_acc, 3);
    chk("t2_row", last_row_acc, 7);
    chk("t2_addr", last_addr_acc, 12'hABC);
    chk("t2_x", last_x_acc, 300);
    load_t2(1);
    acc_cnt = 0;
    start_scan(107);
    run_until_done(600, 0, n);
    chk("t2_vflip_row", last_row_acc, 8);
`ifdef SPRITE_FETCH_OVERFLOW_EN
    chk("no_overflow_main", ovf, 0);
`endif

    // Negative Y via wrap; enable dropped mid-scan must not stop it
    clear_mem();
    mem[0] = mk_w0(12'h011, 0, 7);
    mem[1] = mk_w1(1020, 0, 0, 1, 0, 0, 0, 0);
    acc_cnt = 0;
    start_scan(2);
    enable = 1'b0;
    run_until_done(600, 0, n);
    enable = 1'b1;
    chk("wrap_count", acc_cnt, 1);
    chk("wrap_idx", last_idx_acc, 0);
    chk("wrap_row", last_row_acc, 6);
    acc_cnt = 0;
    start_scan(4);
    run_until_done(600, 0, n);
    chk("wrap_miss", acc_cnt, 0);

    // Several sprites with a stuttering renderer
    clear_mem();
    mem[2]  = 32'h0123_4567; mem[3]  = mk_w1(10, 1, 0, 1, 3, 4, 1, 2);
    mem[5]  = mk_w1(20, 0, 0, 0, 0, 0, 0, 3);
    mem[8]  = 32'h89AB_CDEF; mem[9]  = mk_w1(20, 0, 1, 3, 15, 1, 3, 0);
    mem[18] = 32'h0F0F_8F0F; mem[19] = mk_w1(0, 0, 0, 2, 6, 12, 0, 3);
    build_exp(25);
    chk("model_multi_size", exp_q.size(), 3);
    chk("model_multi_vflip_row", exp_q[1][18:13], 2);
    acc_cnt = 0;
    start_scan(25);
    run_until_done(800, 3, n);
    chk("multi_count", acc_cnt, 3);
    chk("multi_last_idx", last_idx_acc, 9);
    chk("multi_last_row", last_row_acc, 25);

    // Renderer stall: record held, no RAM traffic
    load_t2(0);
    acc_cnt = 0;
    ready = 1'b0;
    start_scan(107);
    wait_valid(600);
    snap = act_rec;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_hold", {spr_valid, rd_en, act_rec}, {1'b1, 1'b0, snap});
    end
    ready = 1'b1;
    tick();
    chk("accept_on_ready", spr_valid, 0);
    chk("stall_accepted", acc_cnt, 1);
    run_until_done(600, 0, n);

    // Restart mid-scan
    load_t2(0);
    mem[20] = mk_w0(12'h055, 0, 40);
    mem[21] = mk_w1(50, 0, 0, 1, 0, 0, 0, 0);
    done_cnt = 0; acc_cnt = 0;
    ready = 1'b0;
    start_scan(107);
    wait_valid(600);
    chk_en = 1'b0;
    start_scan(50);
    chk("abort_valid_drop", spr_valid, 0);
    chk("abort_restart_addr", {rd_en, rd_addr}, {1'b1, 8'd1});
    chk_en = 1'b1;
    ready = 1'b1;
    run_until_done(600, 0, n);
    chk("abort_count", acc_cnt, 1);
    chk("abort_idx", last_idx_acc, 10);
    chk("abort_single_done", done_cnt, 1);

    // Disabled layer ignores line_start
    enable = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    chk("disabled_no_scan", {busy, rd_en}, 0);
    enable = 1'b1;

    // Async reset while a record is held
    load_t2(0);
    ready = 1'b0;
    start_scan(107);
    wait_valid(600);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_emit", all_outs, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    tick();
    chk("idle_after_reset", busy, 0);

    // Per-line limit with 70 visible sprites
    acc70 = 0;
    start70 = 1'b1;
    tick();
    start70 = 1'b0;
    n = 0;
    while (!done70 && n < 1000) begin
      tick();
      n++;
    end
    chk("limit_done_seen", done70, 1);
    tick();
    chk("limit_count", acc70, 64);
`ifdef SPRITE_FETCH_OVERFLOW_EN
    chk("overflow_set", ovf70, 1);
    ovf_clr70 = 1'b1;
    tick();
    ovf_clr70 = 1'b0;
    chk("overflow_clear", ovf70, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
